// File: rtl/gold_code_checker.sv
// -----------------------------------------------------------------------------
// gold_code_checker
// Regenerates a GPS-style gold-code reference locally (G1/G2 LFSRs with a
// two-tap G2 phase select) and compares it chip by chip against a received
// stream. It acquires lock after a run of matches, declares loss after a run
// of mismatches in lock, and keeps a saturating error count since the last load.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset, overrides everything
//   load       : seeds both LFSRs, clears counters, starts acquisition
//   tap_a/b    : G2 phase-select taps (1..10; other values contribute 0)
//   chip_in    : received chip
//   chip_valid : qualifies chip_in for one cycle
//   locked     : high while LOCKED
//   lost       : high while LOST
//   err_count  : saturating mismatch count since last load
//   chip_idx   : index of next expected chip (0..1022)
//   epoch      : one-cycle pulse when chip_idx wraps to 0
// -----------------------------------------------------------------------------
module gold_code_checker #(
    parameter int unsigned LOCK_MATCHES    = 16,
    parameter int unsigned LOSS_MISMATCHES = 4,
    parameter int unsigned ERR_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       tap_a,
    input  logic [3:0]       tap_b,
    input  logic             chip_in,
    input  logic             chip_valid,
    output logic             locked,
    output logic             lost,
    output logic [ERR_W-1:0] err_count,
    output logic [9:0]       chip_idx,
    output logic             epoch
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;

    localparam int unsigned MRUN_W = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned XRUN_W = $clog2(LOSS_MISMATCHES + 1);

    state_t            state;
    logic [10:1]       g1;
    logic [10:1]       g2;
    logic [MRUN_W-1:0] match_run;
    logic [XRUN_W-1:0] miss_run;

    logic g1_fb;
    logic g2_fb;
    logic ref_chip;
    logic mismatch;
    logic accept;

    // Out-of-range tap values select nothing, so they contribute a 0 term.
    function automatic logic tap_bit(input logic [10:1] g, input logic [3:0] n);
        logic b;
        b = 1'b0;
        for (int unsigned i = 1; i <= 10; i++) begin
            if (n == 4'(i)) b = g[i];
        end
        return b;
    endfunction

    always_comb begin
        g1_fb    = g1[3] ^ g1[10];
        g2_fb    = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        ref_chip = g1[10] ^ tap_bit(g2, tap_a) ^ tap_bit(g2, tap_b);
        mismatch = chip_in ^ ref_chip;
        accept   = chip_valid && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g1        <= '1;
            g2        <= '1;
            chip_idx  <= '0;
            err_count <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            lost      <= 1'b0;
            epoch     <= 1'b0;
        end else begin
            epoch <= 1'b0;
            if (load) begin
                state     <= ACQ;
                g1        <= '1;
                g2        <= '1;
                chip_idx  <= '0;
                err_count <= '0;
                match_run <= '0;
                miss_run  <= '0;
                locked    <= 1'b0;
                lost      <= 1'b0;
            end else if (accept) begin
                g1 <= {g1[9:1], g1_fb};
                g2 <= {g2[9:1], g2_fb};

                if (chip_idx == 10'd1022) begin
                    chip_idx <= '0;
                    epoch    <= 1'b1;
                end else begin
                    chip_idx <= chip_idx + 10'd1;
                end

                if (mismatch && (err_count != '1)) begin
                    err_count <= err_count + ERR_W'(1);
                end

                // locked/lost are updated alongside the state so they stay registered.
                case (state)
                    ACQ: begin
                        if (mismatch) begin
                            match_run <= '0;
                        end else if (match_run == MRUN_W'(LOCK_MATCHES - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_run <= '0;
                        end else begin
                            match_run <= match_run + MRUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!mismatch) begin
                            miss_run <= '0;
                        end else if (miss_run == XRUN_W'(LOSS_MISMATCHES - 1)) begin
                            state    <= LOST;
                            locked   <= 1'b0;
                            lost     <= 1'b1;
                            miss_run <= '0;
                        end else begin
                            miss_run <= miss_run + XRUN_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gold_code_checker.sv
// -----------------------------------------------------------------------------
// tb_gold_code_checker
// Self-checking bench for gold_code_checker. The reference model holds the
// G1 and G2 output sequences for one full period; a G2 tap n is the G2 output
// sequence advanced by (10-n) chips, so the expected chip at index k is
// g1seq[k] ^ g2seq[k+10-a] ^ g2seq[k+10-b] (mod 1023).
// -----------------------------------------------------------------------------
module tb_gold_code_checker;

    localparam int ERR_W   = 8;
    localparam int ERR_MAX = 255;
    localparam int LOCK_N  = 16;
    localparam int LOSS_N  = 4;
    localparam int S_IDLE  = 0;
    localparam int S_ACQ   = 1;
    localparam int S_LOCK  = 2;
    localparam int S_LOST  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0;
    logic [3:0]       tap_a = 4'd1;
    logic [3:0]       tap_b = 4'd1;
    logic             chip_in = 1'b0;
    logic             chip_valid = 1'b0;
    logic             locked;
    logic             lost;
    logic [ERR_W-1:0] err_count;
    logic [9:0]       chip_idx;
    logic             epoch;

    int checks = 0;
    int failures = 0;

    bit g1seq [0:1022];
    bit g2seq [0:1022];

    int m_state = S_IDLE;
    int m_idx   = 0;
    int m_err   = 0;
    int m_mrun  = 0;
    int m_xrun  = 0;
    bit m_epoch = 1'b0;

    gold_code_checker #(
        .LOCK_MATCHES   (LOCK_N),
        .LOSS_MISMATCHES(LOSS_N),
        .ERR_W          (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .tap_a     (tap_a),
        .tap_b     (tap_b),
        .chip_in   (chip_in),
        .chip_valid(chip_valid),
        .locked    (locked),
        .lost      (lost),
        .err_count (err_count),
        .chip_idx  (chip_idx),
        .epoch     (epoch)
    );

    always #5 clk = ~clk;

    function automatic bit tap_seq(input int k, input int n);
        if (n < 1 || n > 10) return 1'b0;
        return g2seq[(k + 10 - n) % 1023];
    endfunction

    function automatic bit exp_chip(input int k, input int a, input int b);
        return g1seq[k] ^ tap_seq(k, a) ^ tap_seq(k, b);
    endfunction

    function automatic bit good(input int a, input int b);
        return exp_chip(m_idx, a, b);
    endfunction

    task automatic build_sequences();
        logic [10:1] s1;
        logic [10:1] s2;
        logic f1;
        logic f2;
        s1 = '1;
        s2 = '1;
        for (int k = 0; k < 1023; k++) begin
            g1seq[k] = s1[10];
            g2seq[k] = s2[10];
            f1 = s1[3] ^ s1[10];
            f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
            s1 = {s1[9:1], f1};
            s2 = {s2[9:1], f2};
        end
    endtask

    // Drives one cycle of inputs, advances past the edge, and updates the model.
    task automatic cycle(input bit r, input bit ld, input bit v, input bit c,
                         input int a, input int b);
        bit mis;
        rst = r; load = ld; chip_valid = v; chip_in = c;
        tap_a = 4'(a); tap_b = 4'(b);
        @(posedge clk);
        #1;
        m_epoch = 1'b0;
        if (r) begin
            m_state = S_IDLE; m_idx = 0; m_err = 0; m_mrun = 0; m_xrun = 0;
        end else if (ld) begin
            m_state = S_ACQ; m_idx = 0; m_err = 0; m_mrun = 0; m_xrun = 0;
        end else if (v && m_state != S_IDLE) begin
            mis = (c != exp_chip(m_idx, a, b));
            if (mis && m_err < ERR_MAX) m_err++;
            if (m_idx == 1022) begin
                m_idx = 0;
                m_epoch = 1'b1;
            end else begin
                m_idx++;
            end
            if (m_state == S_ACQ) begin
                if (mis) m_mrun = 0;
                else begin
                    m_mrun++;
                    if (m_mrun == LOCK_N) begin m_state = S_LOCK; m_mrun = 0; end
                end
            end else if (m_state == S_LOCK) begin
                if (!mis) m_xrun = 0;
                else begin
                    m_xrun++;
                    if (m_xrun == LOSS_N) begin m_state = S_LOST; m_xrun = 0; end
                end
            end
        end
        rst = 1'b0; load = 1'b0; chip_valid = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 3, 4);
        checks++;
        if ({locked, lost, epoch} !== 3'b000 || err_count !== '0 || chip_idx !== '0) begin
            failures++;
            $display("FAIL reset: locked=%0b lost=%0b epoch=%0b err=%0d idx=%0d required 0 0 0 0 0",
                     locked, lost, epoch, err_count, chip_idx);
        end
        // IDLE ignores chips.
        cycle(0, 0, 1, 0, 3, 4);
        checks++;
        if (chip_idx !== '0 || err_count !== '0) begin
            failures++;
            $display("FAIL idle_ignore: idx=%0d err=%0d required 0 0", chip_idx, err_count);
        end
    endtask

    task automatic test_full_sequence();
        int epochs;
        epochs = 0;
        cycle(0, 1, 0, 0, 2, 6);
        for (int i = 1; i <= 1023; i++) begin
            cycle(0, 0, 1, good(2, 6), 2, 6);
            if (epoch) epochs++;
            checks++;
            if ({locked, lost, epoch} !== {m_state == S_LOCK, m_state == S_LOST, m_epoch}
                || err_count !== ERR_W'(m_err) || chip_idx !== 10'(m_idx)) begin
                failures++;
                $display("FAIL full_seq chip %0d: l=%0b lo=%0b ep=%0b err=%0d idx=%0d required %0b %0b %0b %0d %0d",
                         i, locked, lost, epoch, err_count, chip_idx,
                         m_state == S_LOCK, m_state == S_LOST, m_epoch, m_err, m_idx);
            end
            if (i == 15) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL early_lock: locked=%0b required 0", locked);
                end
            end
            if (i == 16) begin
                checks++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_at_16: locked=%0b required 1", locked);
                end
            end
        end
        checks++;
        if (epochs != 1 || err_count !== '0 || chip_idx !== '0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL full_seq_end: epochs=%0d err=%0d idx=%0d locked=%0b required 1 0 0 1",
                     epochs, err_count, chip_idx, locked);
        end
    endtask

    task automatic test_loss();
        int pre;
        pre = 5 + int'($urandom_range(40));
        for (int i = 0; i < pre; i++) cycle(0, 0, 1, good(2, 6), 2, 6);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, !good(2, 6), 2, 6);
        checks++;
        if (locked !== 1'b1 || lost !== 1'b0 || err_count !== 8'd3) begin
            failures++;
            $display("FAIL flip3: locked=%0b lost=%0b err=%0d required 1 0 3", locked, lost, err_count);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, good(2, 6), 2, 6);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, !good(2, 6), 2, 6);
        checks++;
        if (locked !== 1'b0 || lost !== 1'b1 || err_count !== 8'd7) begin
            failures++;
            $display("FAIL flip4: locked=%0b lost=%0b err=%0d required 0 1 7", locked, lost, err_count);
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, good(2, 6), 2, 6);
        cycle(0, 0, 1, !good(2, 6), 2, 6);
        checks++;
        if (locked !== 1'b0 || lost !== 1'b1 || err_count !== 8'd8) begin
            failures++;
            $display("FAIL lost_persist: locked=%0b lost=%0b err=%0d required 0 1 8", locked, lost, err_count);
        end
    endtask

    task automatic test_saturate();
        int a;
        int b;
        int prev;
        a = 1 + int'($urandom_range(9));
        b = 1 + int'($urandom_range(9));
        cycle(0, 1, 0, 0, a, b);
        prev = 0;
        for (int i = 0; i < 600; i++) begin
            cycle(0, 0, 1, (($urandom % 4) == 0) ? good(a, b) : !good(a, b), a, b);
            checks++;
            if (int'(err_count) < prev || err_count !== ERR_W'(m_err)) begin
                failures++;
                $display("FAIL sat_step %0d: err=%0d prev=%0d required %0d", i, err_count, prev, m_err);
            end
            prev = int'(err_count);
        end
        checks++;
        if (err_count !== 8'd255 || locked !== 1'b0) begin
            failures++;
            $display("FAIL saturate: err=%0d locked=%0b required 255 0", err_count, locked);
        end
    endtask

    task automatic test_load_with_valid();
        cycle(0, 1, 0, 0, 3, 7);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, good(3, 7), 3, 7);
        cycle(0, 1, 1, $urandom % 2, 3, 7);
        checks++;
        if (chip_idx !== '0 || err_count !== '0 || locked !== 1'b0 || lost !== 1'b0) begin
            failures++;
            $display("FAIL load_valid: idx=%0d err=%0d locked=%0b lost=%0b required 0 0 0 0",
                     chip_idx, err_count, locked, lost);
        end
        cycle(0, 0, 1, good(3, 7), 3, 7);
        checks++;
        if (chip_idx !== 10'd1 || err_count !== '0) begin
            failures++;
            $display("FAIL load_acq: idx=%0d err=%0d required 1 0", chip_idx, err_count);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(0, 1, 0, 0, 1, 9);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, good(1, 9), 1, 9);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_lock: locked=%0b required 1", locked);
        end
        cycle(1, 0, 1, 1, 1, 9);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, $urandom % 2, 1, 9);
            checks++;
            if ({locked, lost, epoch} !== 3'b000 || err_count !== '0 || chip_idx !== '0) begin
                failures++;
                $display("FAIL rst_mid %0d: locked=%0b lost=%0b epoch=%0b err=%0d idx=%0d required 0 0 0 0 0",
                         i, locked, lost, epoch, err_count, chip_idx);
            end
        end
    endtask

    task automatic test_gapped();
        int nvalid;
        bit v;
        nvalid = 0;
        cycle(0, 1, 0, 0, 5, 5);
        for (int c = 0; c < 60; c++) begin
            v = (c % 3) == 0;
            // Equal taps cancel, leaving the bare G1 sequence.
            cycle(0, 0, v, v ? g1seq[m_idx] : bit'($urandom % 2), 5, 5);
            if (v) nvalid++;
            checks++;
            if ({locked, lost, epoch} !== {m_state == S_LOCK, m_state == S_LOST, m_epoch}
                || err_count !== ERR_W'(m_err) || chip_idx !== 10'(nvalid)) begin
                failures++;
                $display("FAIL gapped cyc %0d: l=%0b lo=%0b err=%0d idx=%0d required %0b %0b %0d %0d",
                         c, locked, lost, err_count, chip_idx,
                         m_state == S_LOCK, m_state == S_LOST, m_err, nvalid);
            end
            if (v && nvalid == 15 && locked !== 1'b0) begin
                failures++;
                $display("FAIL gapped_early: locked=%0b required 0", locked);
            end
            if (v && nvalid == 16) begin
                checks++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL gapped_lock: locked=%0b required 1", locked);
                end
            end
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        bit v;
        bit c;
        a = int'($urandom_range(15));
        b = int'($urandom_range(15));
        cycle(0, 1, 0, 0, a, b);
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 40) == 0) a = int'($urandom_range(15));
            if (($urandom % 40) == 0) b = int'($urandom_range(15));
            v = ($urandom % 2) == 1;
            c = (($urandom % 10) == 0) ? !good(a, b) : good(a, b);
            cycle(0, ($urandom % 150) == 0, v, c, a, b);
            checks++;
            if ({locked, lost, epoch} !== {m_state == S_LOCK, m_state == S_LOST, m_epoch}
                || err_count !== ERR_W'(m_err) || chip_idx !== 10'(m_idx)) begin
                failures++;
                $display("FAIL random %0d: l=%0b lo=%0b ep=%0b err=%0d idx=%0d required %0b %0b %0b %0d %0d",
                         i, locked, lost, epoch, err_count, chip_idx,
                         m_state == S_LOCK, m_state == S_LOST, m_epoch, m_err, m_idx);
            end
        end
    endtask

    initial begin
        build_sequences();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_sequence();
        test_loss();
        test_saturate();
        test_load_with_valid();
        test_reset_midstream();
        test_gapped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
